// File: rtl/multi_counter_sat_pkg.sv
// rtl/multi_counter_sat_pkg.sv - op codes and op-class lookups for multi_counter_sat
package multi_counter_sat_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_INIT   = 3'd1,
    OP_INCR   = 3'd2,
    OP_DECR   = 3'd3,
    OP_ADD    = 3'd4,
    OP_SUB    = 3'd5,
    OP_QRY    = 3'd6,
    OP_QRYCLR = 3'd7
  } op_t;

  // One bit per op code: bit n set means op n writes back / produces a response.
  localparam logic [7:0] OP_WR_MASK  = 8'b1011_1110;
  localparam logic [7:0] OP_RSP_MASK = 8'b1100_0000;

  function automatic logic op_writes(input op_t op);
    return OP_WR_MASK[op];
  endfunction

  function automatic logic op_responds(input op_t op);
    return OP_RSP_MASK[op];
  endfunction

  function automatic logic op_clears_flag(input op_t op);
    return (op == OP_INIT) || (op == OP_QRYCLR);
  endfunction

endpackage

// File: rtl/multi_counter_sat_alu.sv
// rtl/multi_counter_sat_alu.sv - next-value datapath with carry/borrow detect and optional clamp
module multi_counter_sat_alu
  import multi_counter_sat_pkg::*;
#(
  parameter int W   = 32,
  parameter int SAT = 1
) (
  input  logic [W-1:0] i_value,
  input  logic [W-1:0] i_operand,
  input  op_t          i_op,
  output logic [W-1:0] o_result,
  output logic         o_ovf
);

  logic [W-1:0] w_rhs;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;

  assign w_rhs  = ((i_op == OP_INCR) || (i_op == OP_DECR)) ? W'(1) : i_operand;
  assign w_sum  = {1'b0, i_value} + {1'b0, w_rhs};
  assign w_diff = {1'b0, i_value} - {1'b0, w_rhs};

  always_comb begin
    o_result = i_value;
    o_ovf    = 1'b0;
    case (i_op)
      OP_INIT:   o_result = i_operand;
      OP_INCR, OP_ADD: begin
        o_ovf    = w_sum[W];
        o_result = ((SAT != 0) && w_sum[W]) ? {W{1'b1}} : w_sum[W-1:0];
      end
      OP_DECR, OP_SUB: begin
        o_ovf    = w_diff[W];
        o_result = ((SAT != 0) && w_diff[W]) ? {W{1'b0}} : w_diff[W-1:0];
      end
      OP_QRYCLR: o_result = {W{1'b0}};
      default:   o_result = i_value;
    endcase
  end

endmodule

// File: rtl/multi_counter_sat.sv
// rtl/multi_counter_sat.sv - bank of N counters with 2-stage execute/write-back pipeline and clear sweep
module multi_counter_sat
  import multi_counter_sat_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 32,
  parameter int SAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_pass,
  input  op_t                  cmd_op,
  input  logic [$clog2(N)-1:0] cmd_id,
  input  logic [W-1:0]         cmd_dat,
  output logic                 busy_r,
  output logic                 rsp_pass_r,
  output logic [$clog2(N)-1:0] rsp_id_r,
  output logic [W-1:0]         rsp_dat_r,
  output logic                 rsp_ovf_r
);

  localparam int IW = $clog2(N);

  logic [W-1:0]  r_mem [N];
  logic          r_flg [N];
  logic [IW-1:0] r_sweep_idx;

  logic          r_s1_vld;
  op_t           r_s1_op;
  logic [IW-1:0] r_s1_id;
  logic [W-1:0]  r_s1_dat;

  logic          r_s2_vld;
  op_t           r_s2_op;
  logic [IW-1:0] r_s2_id;
  logic [W-1:0]  r_s2_val;
  logic          r_s2_flg;
  logic [W-1:0]  r_s2_pre_val;
  logic          r_s2_pre_flg;

  logic          w_fwd;
  logic [W-1:0]  w_cur_val;
  logic          w_cur_flg;
  logic [W-1:0]  w_alu_res;
  logic          w_alu_ovf;
  logic          w_new_flg;

  logic          w_we;
  logic [IW-1:0] w_waddr;
  logic [W-1:0]  w_wval;
  logic          w_wflg;

  // S2 holds the only write not yet in the array, so one bypass level suffices.
  assign w_fwd     = r_s2_vld && op_writes(r_s2_op) && (r_s2_id == r_s1_id);
  assign w_cur_val = w_fwd ? r_s2_val : r_mem[r_s1_id];
  assign w_cur_flg = w_fwd ? r_s2_flg : r_flg[r_s1_id];
  assign w_new_flg = op_clears_flag(r_s1_op) ? 1'b0 : (w_cur_flg | w_alu_ovf);

  multi_counter_sat_alu #(
    .W   (W),
    .SAT (SAT)
  ) u_alu (
    .i_value   (w_cur_val),
    .i_operand (r_s1_dat),
    .i_op      (r_s1_op),
    .o_result  (w_alu_res),
    .o_ovf     (w_alu_ovf)
  );

  // The pipeline is empty whenever the sweep runs, so the two writers never collide.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sweep_idx;
    w_wval  = '0;
    w_wflg  = 1'b0;
    if (rst_n) begin
      if (busy_r) begin
        w_we = 1'b1;
      end else if (r_s2_vld && op_writes(r_s2_op)) begin
        w_we    = 1'b1;
        w_waddr = r_s2_id;
        w_wval  = r_s2_val;
        w_wflg  = r_s2_flg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wval;
      r_flg[w_waddr] <= w_wflg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r      <= 1'b1;
      r_sweep_idx <= '0;
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      rsp_pass_r  <= 1'b0;
    end else begin
      if (busy_r) begin
        r_sweep_idx <= r_sweep_idx + IW'(1);
        if (r_sweep_idx == IW'(N - 1)) busy_r <= 1'b0;
      end

      r_s1_vld <= cmd_pass && !busy_r && (cmd_op != OP_NOP);
      r_s1_op  <= cmd_op;
      r_s1_id  <= cmd_id;
      r_s1_dat <= cmd_dat;

      r_s2_vld     <= r_s1_vld;
      r_s2_op      <= r_s1_op;
      r_s2_id      <= r_s1_id;
      r_s2_val     <= w_alu_res;
      r_s2_flg     <= w_new_flg;
      r_s2_pre_val <= w_cur_val;
      r_s2_pre_flg <= w_cur_flg;

      rsp_pass_r <= r_s2_vld && op_responds(r_s2_op);
      if (r_s2_vld && op_responds(r_s2_op)) begin
        rsp_id_r  <= r_s2_id;
        rsp_dat_r <= r_s2_pre_val;
        rsp_ovf_r <= r_s2_pre_flg;
      end
    end
  end

endmodule

// File: tb/tb_multi_counter_sat.sv
// tb/tb_multi_counter_sat.sv - self-checking bench for multi_counter_sat, saturating and wrapping instances
module tb_multi_counter_sat;
  import multi_counter_sat_pkg::*;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_pass;
  op_t        cmd_op;
  logic [1:0] cmd_id;
  logic [7:0] cmd_dat;

  logic       s_busy, s_pass, s_ovf;
  logic [1:0] s_id;
  logic [7:0] s_dat;
  logic       w_busy, w_pass, w_ovf;
  logic [1:0] w_id;
  logic [7:0] w_dat;

  always #5 clk = ~clk;

  multi_counter_sat #(.W(W), .N(N), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .cmd_pass(cmd_pass), .cmd_op(cmd_op), .cmd_id(cmd_id),
    .cmd_dat(cmd_dat), .busy_r(s_busy), .rsp_pass_r(s_pass), .rsp_id_r(s_id),
    .rsp_dat_r(s_dat), .rsp_ovf_r(s_ovf)
  );

  multi_counter_sat #(.W(W), .N(N), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .cmd_pass(cmd_pass), .cmd_op(cmd_op), .cmd_id(cmd_id),
    .cmd_dat(cmd_dat), .busy_r(w_busy), .rsp_pass_r(w_pass), .rsp_id_r(w_id),
    .rsp_dat_r(w_dat), .rsp_ovf_r(w_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: counters as plain integers, commands applied in issue order.
  typedef struct {
    int due;
    int id;
    int d_s;
    int o_s;
    int d_w;
    int o_w;
  } exp_t;

  exp_t rsp_q[$];
  int   m_val [2][N];
  int   m_flg [2][N];
  int   m_busy_left = N;
  int   cyc = 0;
  bit   m_live = 0;
  bit   m_have_rsp = 0;
  int   m_last_s = 0;

  task automatic m_apply(input op_t op, input int id, input int dat);
    exp_t e;
    int   v;
    int   r;
    e.due = cyc + 2;
    e.id  = id;
    for (int s = 0; s < 2; s++) begin
      v = m_val[s][id];
      r = v;
      if (s == 0) begin e.d_s = v; e.o_s = m_flg[s][id]; end
      else        begin e.d_w = v; e.o_w = m_flg[s][id]; end
      case (op)
        OP_INIT:   begin r = dat; m_flg[s][id] = 0; end
        OP_INCR:   r = v + 1;
        OP_DECR:   r = v - 1;
        OP_ADD:    r = v + dat;
        OP_SUB:    r = v - dat;
        OP_QRYCLR: begin r = 0; m_flg[s][id] = 0; end
        default:   r = v;
      endcase
      if (r > MAXV || r < 0) begin
        m_flg[s][id] = 1;
        if (s == 0) r = (r > MAXV) ? MAXV : 0;
        else        r = r & MAXV;
      end
      m_val[s][id] = r;
    end
    if (op == OP_QRY || op == OP_QRYCLR) rsp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_live = 1;
      m_busy_left = N;
      rsp_q.delete();
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < N; i++) begin
          m_val[s][i] = 0;
          m_flg[s][i] = 0;
        end
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (cmd_pass && cmd_op != OP_NOP) begin
      m_apply(cmd_op, int'(cmd_id), int'(cmd_dat));
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      bit exp_pass;
      exp_pass = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
      chk("busy_s", int'(s_busy), int'(m_busy_left > 0));
      chk("busy_w", int'(w_busy), int'(m_busy_left > 0));
      chk("rsp_pass_s", int'(s_pass), int'(exp_pass));
      chk("rsp_pass_w", int'(w_pass), int'(exp_pass));
      if (exp_pass) begin
        chk("rsp_id_s", int'(s_id), rsp_q[0].id);
        chk("rsp_id_w", int'(w_id), rsp_q[0].id);
        chk("rsp_dat_s", int'(s_dat), rsp_q[0].d_s);
        chk("rsp_ovf_s", int'(s_ovf), rsp_q[0].o_s);
        chk("rsp_dat_w", int'(w_dat), rsp_q[0].d_w);
        chk("rsp_ovf_w", int'(w_ovf), rsp_q[0].o_w);
        m_last_s = rsp_q[0].d_s;
        m_have_rsp = 1;
        void'(rsp_q.pop_front());
      end else if (m_have_rsp) begin
        chk("rsp_dat_hold_s", int'(s_dat), m_last_s);
      end
    end
  end

  task automatic issue(input op_t op, input int id, input int dat);
    cmd_pass = 1'b1;
    cmd_op   = op;
    cmd_id   = 2'(id);
    cmd_dat  = 8'(dat);
    @(negedge clk);
    cmd_pass = 1'b0;
  endtask

  // Waits (bounded) for the next response and checks it against literal values.
  task automatic expect_rsp(input string name, input int id, input int d_s, input int o_s,
                            input int d_w, input int o_w, output int lat);
    cmd_pass = 1'b0;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      if (s_pass === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_seen"}, int'(s_pass === 1'b1), 1);
    if (lat >= 0) begin
      chk({name, "_id"}, int'(s_id), id);
      chk({name, "_dat_sat"}, int'(s_dat), d_s);
      chk({name, "_ovf_sat"}, int'(s_ovf), o_s);
      chk({name, "_dat_wrap"}, int'(w_dat), d_w);
      chk({name, "_ovf_wrap"}, int'(w_ovf), o_w);
      @(negedge clk);
    end
  endtask

  // Holds reset, releases it, and counts busy cycles while pushing commands that must be dropped.
  task automatic do_reset(input int hold, input string name);
    int cnt;
    rst_n = 1'b0;
    cmd_pass = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (s_busy === 1'b1 && cnt < 50) begin
      cmd_pass = 1'b1;
      cmd_op   = cnt[0] ? OP_QRY : OP_INIT;
      cmd_id   = 2'(cnt);
      cmd_dat  = 8'd99;
      cnt++;
      @(negedge clk);
    end
    cmd_pass = 1'b0;
    chk(name, cnt, N);
  endtask

  initial begin
    int lat;
    rst_n    = 1'b0;
    cmd_pass = 1'b0;
    cmd_op   = OP_NOP;
    cmd_id   = 2'd0;
    cmd_dat  = 8'd0;
    @(negedge clk);

    do_reset(3, "busy_len_initial");
    for (int i = 0; i < N; i++) begin
      issue(OP_QRY, i, 0);
      expect_rsp($sformatf("post_reset_q%0d", i), i, 0, 0, 0, 0, lat);
    end

    issue(OP_INIT, 1, 250);
    repeat (10) issue(OP_INCR, 1, 0);
    issue(OP_QRY, 1, 0);
    expect_rsp("incr_ovf", 1, 255, 1, 4, 1, lat);

    issue(OP_INIT, 2, 3);
    issue(OP_SUB, 2, 5);
    issue(OP_QRYCLR, 2, 0);
    issue(OP_QRY, 2, 0);
    expect_rsp("sub_qryclr", 2, 0, 1, 254, 1, lat);
    expect_rsp("after_clr", 2, 0, 0, 0, 0, lat);

    issue(OP_INIT, 0, 7);
    issue(OP_INCR, 0, 0);
    issue(OP_QRY, 0, 0);
    expect_rsp("fwd", 0, 8, 0, 8, 0, lat);
    chk("fwd_latency", lat, 2);

    issue(OP_INIT, 0, 200);
    issue(OP_INIT, 1, 10);
    issue(OP_INIT, 2, 128);
    issue(OP_INIT, 3, 1);
    issue(OP_ADD, 0, 100);
    issue(OP_NOP, 1, 55);
    issue(OP_ADD, 1, 100);
    issue(OP_SUB, 3, 2);
    issue(OP_ADD, 2, 127);
    issue(OP_DECR, 2, 0);
    issue(OP_QRY, 0, 0);
    issue(OP_QRY, 1, 0);
    issue(OP_QRY, 2, 0);
    issue(OP_QRY, 3, 0);
    issue(OP_QRYCLR, 3, 0);
    issue(OP_QRY, 3, 0);
    issue(OP_DECR, 3, 0);
    issue(OP_QRY, 3, 0);
    repeat (4) @(negedge clk);

    issue(OP_INIT, 1, 50);
    issue(OP_QRY, 1, 0);
    do_reset(2, "busy_len_mid_stream");

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_reset(1, "busy_len_sweep_abort");
    issue(OP_QRY, 1, 0);
    expect_rsp("after_abort_q1", 1, 0, 0, 0, 0, lat);
    issue(OP_QRY, 3, 0);
    expect_rsp("after_abort_q3", 3, 0, 0, 0, 0, lat);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
